// File: rtl/stp_pkg.sv
// Shared definitions for the serial-to-parallel framer: width helpers,
// complex-word packing and the output-register action encoding.
package stp_pkg;

  localparam int DEF_DW = 16;
  localparam int CW     = 2 * DEF_DW;
  // Widest sample the packing helpers handle.
  localparam int MAX_DW = 32;

  // What the output register does on a given edge.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_DROP,
    ACT_DRAIN
  } out_act_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Complex word {re, im=0}. The caller keeps the low 2*dw bits.
  function automatic logic [2*MAX_DW-1:0] cplx_pack(input logic [MAX_DW-1:0] re,
                                                    input int dw);
    return {{MAX_DW{1'b0}}, re} << dw;
  endfunction

  function automatic logic [MAX_DW-1:0] cplx_re(input logic [2*MAX_DW-1:0] word,
                                                input int dw);
    logic [2*MAX_DW-1:0] s;
    s = word >> dw;
    return s[MAX_DW-1:0];
  endfunction

endpackage

// File: rtl/stp_frame_buf.sv
// Serial-to-parallel framer: collects N real samples (optionally overlapped by
// HOP) and presents them as N complex words behind a held valid/ready register.
module stp_frame_buf
  import stp_pkg::*;
#(
  parameter int DW  = 16,
  parameter int N   = 16,
  parameter int HOP = N
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*2*DW-1:0] out_d,
  output logic              ovf
);

  localparam int WORD_W = 2 * DW;
  localparam int CNT_W  = clog2(N) + 1;

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(N);
  localparam logic [CNT_W-1:0] HOP_LAST  = CNT_W'(HOP - 1);

  logic [DW-1:0]       sh [N];
  logic [N*WORD_W-1:0] frame_nxt;
  logic [CNT_W-1:0]    fill;
  logic [CNT_W-1:0]    hop;
  logic                primed;
  logic                fire;
  out_act_e            act;

  // Shift line: oldest sample at index 0, newest enters at N-1.
  // NOTE: the shift line is reset because its clear state is part of the
  // block's defined reset behaviour; sequential state always uses <=.
  for (genvar k = 0; k < N; k++) begin : g_shift
    if (k == N - 1) begin : g_tail
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)           sh[k] <= '0;
        else if (in_valid) sh[k] <= in_d;
      end
    end else begin : g_body
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)           sh[k] <= '0;
        else if (in_valid) sh[k] <= sh[k+1];
      end
    end
  end

  // Capture bypasses the current sample so the frame is ready on its last edge.
  for (genvar k = 0; k < N; k++) begin : g_capture
    if (k == N - 1) begin : g_new
      assign frame_nxt[k*WORD_W +: WORD_W] = WORD_W'(cplx_pack(MAX_DW'(in_d), DW));
    end else begin : g_old
      assign frame_nxt[k*WORD_W +: WORD_W] = WORD_W'(cplx_pack(MAX_DW'(sh[k+1]), DW));
    end
  end

  assign fire = in_valid && (primed ? (hop == HOP_LAST) : (fill == FILL_LAST));

  // A gap in the stream throws away both the partial frame and overlap history.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fill   <= '0;
      hop    <= '0;
      primed <= 1'b0;
    end else if (!in_valid) begin
      fill   <= '0;
      hop    <= '0;
      primed <= 1'b0;
    end else begin
      if (fill != FILL_FULL) fill <= fill + 1'b1;
      if (fire || hop == HOP_LAST) hop <= '0;
      else                         hop <= hop + 1'b1;
      if (fire) primed <= 1'b1;
    end
  end

  // NOTE: act gets a default before any branch so no latch is inferred.
  always_comb begin
    act = ACT_HOLD;
    if (fire) begin
      if (out_valid && !out_ready) act = ACT_DROP;
      else                         act = ACT_LOAD;
    end else if (out_ready) begin
      act = ACT_DRAIN;
    end
  end

  // A held frame is never overwritten; a frame that cannot be loaded is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_d     <= '0;
      ovf       <= 1'b0;
    end else begin
      ovf <= (act == ACT_DROP);
      case (act)
        ACT_LOAD: begin
          out_valid <= 1'b1;
          out_d     <= frame_nxt;
        end
        ACT_DRAIN: out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stp_frame_buf.sv
// Bench for stp_frame_buf: a non-overlapped (HOP=16) and an overlapped (HOP=8)
// instance share one stimulus stream and are compared against a queue model.
module tb_stp_frame_buf;

  localparam int DW    = 16;
  localparam int N     = 16;
  localparam int FW    = N * 2 * DW;
  localparam int HOP_A = 16;
  localparam int HOP_B = 8;

  logic          CLK;
  logic          RST;
  logic          in_valid;
  logic [DW-1:0] in_d;
  logic          out_ready;
  logic          a_valid, b_valid;
  logic [FW-1:0] a_d, b_d;
  logic          a_ovf, b_ovf;

  stp_frame_buf #(.DW(DW), .N(N), .HOP(HOP_A)) u_dut_a (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_d(in_d),
    .out_valid(a_valid), .out_ready(out_ready), .out_d(a_d), .ovf(a_ovf)
  );

  stp_frame_buf #(.DW(DW), .N(N), .HOP(HOP_B)) u_dut_b (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_d(in_d),
    .out_valid(b_valid), .out_ready(out_ready), .out_d(b_d), .ovf(b_ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: recent sample history plus per-instance run bookkeeping.
  logic [DW-1:0] hist [$];
  int            run_len [2];
  int            since   [2];
  bit            primed  [2];
  bit            exp_v   [2];
  bit            exp_ovf [2];
  logic [FW-1:0] exp_d   [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_a_valid;
  int cnt_a_ovf;

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int hop_of(input int i);
    return (i == 0) ? HOP_A : HOP_B;
  endfunction

  function automatic logic [FW-1:0] frame_of_hist();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++)
      f[k*2*DW +: 2*DW] = {hist[hist.size() - N + k], {DW{1'b0}}};
    return f;
  endfunction

  function automatic logic [FW-1:0] word_exp(input int value);
    logic [FW-1:0] w;
    w = '0;
    w[2*DW-1:0] = {DW'(value), {DW{1'b0}}};
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      run_len[i] = 0;
      since[i]   = 0;
      primed[i]  = 1'b0;
      exp_v[i]   = 1'b0;
      exp_ovf[i] = 1'b0;
      exp_d[i]   = '0;
    end
  endtask

  task automatic model_step(input bit v, input logic [DW-1:0] d, input bit rdy);
    bit fire;
    if (v) begin
      hist.push_back(d);
      if (hist.size() > N) void'(hist.pop_front());
    end
    for (int i = 0; i < 2; i++) begin
      fire       = 1'b0;
      exp_ovf[i] = 1'b0;
      if (!v) begin
        run_len[i] = 0;
        since[i]   = 0;
        primed[i]  = 1'b0;
      end else begin
        run_len[i]++;
        since[i]++;
        if ((!primed[i] && run_len[i] == N) || (primed[i] && since[i] == hop_of(i))) begin
          fire      = 1'b1;
          since[i]  = 0;
          primed[i] = 1'b1;
        end
      end
      if (fire) begin
        if (!exp_v[i] || rdy) begin
          exp_v[i] = 1'b1;
          exp_d[i] = frame_of_hist();
        end else begin
          exp_ovf[i] = 1'b1;
        end
      end else if (rdy) begin
        exp_v[i] = 1'b0;
      end
    end
  endtask

  task automatic compare();
    check("a_valid", FW'(a_valid), FW'(exp_v[0]));
    check("a_d",     a_d,          exp_d[0]);
    check("a_ovf",   FW'(a_ovf),   FW'(exp_ovf[0]));
    check("b_valid", FW'(b_valid), FW'(exp_v[1]));
    check("b_d",     b_d,          exp_d[1]);
    check("b_ovf",   FW'(b_ovf),   FW'(exp_ovf[1]));
    if (a_valid) cnt_a_valid++;
    if (a_ovf)   cnt_a_ovf++;
  endtask

  // Inputs change at the falling edge; outputs are compared at the next one.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit rdy);
    in_valid  = v;
    in_d      = d;
    out_ready = rdy;
    @(posedge CLK);
    model_step(v, d, rdy);
    @(negedge CLK);
    compare();
  endtask

  // Reset is raised between clock edges to exercise its asynchronous path.
  task automatic do_reset();
    #2;
    RST      = 1'b1;
    in_valid = 1'b0;
    model_reset();
    #1;
    compare();
    @(negedge CLK);
    compare();
    RST = 1'b0;
  endtask

  initial begin
    RST       = 1'b0;
    in_valid  = 1'b0;
    in_d      = '0;
    out_ready = 1'b1;
    cnt_a_valid = 0;
    cnt_a_ovf   = 0;
    model_reset();
    @(negedge CLK);
    do_reset();

    // Plain frame: samples 0..15.
    for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), 1'b1);
    check("p1_valid", FW'(a_valid), FW'(1));
    check("p1_w0",    FW'(a_d[0 +: 32]),     word_exp(0));
    check("p1_w15",   FW'(a_d[15*32 +: 32]), word_exp(15));
    check("p1_ovf",   FW'(a_ovf), FW'(0));
    cycle(1'b0, '0, 1'b1);
    check("p1_drop_valid", FW'(a_valid), FW'(0));

    // Overlapped framing on the HOP=8 instance.
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, DW'(i), 1'b1);
      if (i == 15 || i == 23 || i == 31) begin
        check("hop8_valid", FW'(b_valid), FW'(1));
        check("hop8_w0",    FW'(b_d[0 +: 32]),     word_exp(i - 15));
        check("hop8_w15",   FW'(b_d[15*32 +: 32]), word_exp(i));
      end
    end
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Abort: a gap after sample 9 discards the partial frame.
    cnt_a_valid = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'(i), 1'b1);
    cycle(1'b0, '0, 1'b1);
    for (int i = 100; i < 116; i++) cycle(1'b1, DW'(i), 1'b1);
    check("abort_w0",  FW'(a_d[0 +: 32]),     word_exp(100));
    check("abort_w15", FW'(a_d[15*32 +: 32]), word_exp(115));
    cycle(1'b0, '0, 1'b1);
    check("abort_frames", FW'(cnt_a_valid), FW'(1));

    // Back-pressure: first frame held, second dropped with one ovf pulse.
    cycle(1'b0, '0, 1'b1);
    cnt_a_ovf = 0;
    for (int i = 0; i < 32; i++) cycle(1'b1, DW'(i), 1'b0);
    check("bp_ovf",   FW'(a_ovf), FW'(1));
    check("bp_w0",    FW'(a_d[0 +: 32]),     word_exp(0));
    check("bp_w15",   FW'(a_d[15*32 +: 32]), word_exp(15));
    cycle(1'b0, '0, 1'b0);
    check("bp_ovf_once", FW'(cnt_a_ovf), FW'(1));
    check("bp_hold",     FW'(a_valid),   FW'(1));
    cycle(1'b0, '0, 1'b1);
    check("bp_release", FW'(a_valid), FW'(0));

    // Simultaneous: ready arrives on the edge a new frame fires.
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 32; i++) cycle(1'b1, DW'(i), i == 31);
    check("sim_valid", FW'(a_valid), FW'(1));
    check("sim_ovf",   FW'(a_ovf),   FW'(0));
    check("sim_w0",    FW'(a_d[0 +: 32]), word_exp(16));
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Reset mid-frame, then one clean frame.
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(i), 1'b1);
    do_reset();
    check("rst_valid", FW'(a_valid), FW'(0));
    check("rst_d",     a_d, FW'(0));
    for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), 1'b1);
    check("rst_frame_valid", FW'(a_valid), FW'(1));
    check("rst_frame_w15",   FW'(a_d[15*32 +: 32]), word_exp(15));

    // Randomized traffic with occasional gaps, stalls and resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) do_reset();
      else cycle($urandom_range(0, 15) != 0, DW'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stp_frame_buf.md
# stp_frame_buf

Parametrised serial-to-parallel framer between the FIR output and the parallel FFT core. It collects N real samples from the FIR stream, optionally with overlap (hop < N). It presents each frame as N complex words (imaginary part zero) on one packed bus, using a valid/ready handshake. It generalises the fixed 16-point STP stage: it adds configurable depth and width, overlapped framing, back-pressure with a held output register, and overrun reporting.

## Interface
- DW, 16: sample width (signed, two's complement); each complex word is 2*DW bits.
- N, 16: frame length; power of two, 4..64.
- HOP, N: new samples between consecutive frames; 1..N. HOP < N gives overlap.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample strobe; a low cycle aborts the frame in progress.
- in_d  in  DW  signed sample, accepted when in_valid=1.
- out_valid  out  1  frame available on out_d.
- out_ready  in  1  consumer accepts the frame.
- out_d  out  N*2*DW  packed frame; word k at [k*2*DW +: 2*DW] = {sample, DW'd0}; k=0 is the oldest sample.
- ovf  out  1  one-cycle pulse: a completed frame was dropped.

## Operation
- Reset values: out_valid=0, out_d=0, ovf=0. Shift line, fill counter, hop counter and primed flag all clear.
- Shift line of N samples, updated on every accepted sample: sh[k]<=sh[k+1], sh[N-1]<=in_d.
- Fill counter saturates at N. Hop counter runs 0..HOP-1.
- A frame fires on the accepting edge when either condition holds:
  - unprimed and fill==N-1
  - primed and hop==HOP-1
- On fire: hop<=0 and primed<=1.
- Frame capture is a bypass of the current sample: out_d word k <= sh[k+1] for k<N-1, and word N-1 <= in_d.
- Abort: any cycle with in_valid=0 clears fill, hop and primed. The partial frame and the overlap history are discarded. The next frame needs N fresh samples.
- The output register is independent of the shift line. Sampling continues while a frame is held.
- Handshake on fire:
  - out_valid=0, or out_valid=1 with out_ready=1: load the new frame; out_valid stays or goes to 1.
  - out_valid=1 with out_ready=0: keep the held frame unchanged; pulse ovf next cycle. Counters advance as if the frame were emitted.
- No fire and out_ready=1: out_valid<=0. out_d holds its last value.
- The abort does not affect a held frame; out_valid is kept.

## Timing
- Latency: out_valid rises on the edge that accepts the frame's last sample, i.e. visible the cycle after that sample is presented.
- Throughput: one sample per cycle. Minimum frame spacing is HOP cycles.
- out_valid and out_d are stable while out_valid=1 and out_ready=0.
- ovf is registered: high for exactly one cycle, the cycle after the dropping edge.
- RST asserted mid-frame or mid-hold clears everything immediately. There is no out_valid glitch after release.

## Structure
- Shared package stp_pkg:
  - function clog2
  - localparam CW = 2*DW
  - complex word pack/unpack helper (re high, im low)
- No sub-module. Shift line, capture and packing are generate loops in the one module. Counters are clog2(N)+1 bits wide.

## Test plan
- N=16, HOP=16, out_ready=1:
  - Stimulus: samples 0..15 back-to-back.
  - Response: out_valid one cycle; word k = {k, 16'h0000}; ovf=0.
- HOP=8:
  - Stimulus: samples 0..31 contiguous.
  - Response: frames after samples 15, 23, 31, with word 0 = 0, 8, 16 and word 15 = 15, 23, 31.
- Abort:
  - Stimulus: samples 0..9, one in_valid=0 cycle, then 100..115.
  - Response: exactly one frame, words 100..115.
- Back-pressure:
  - Stimulus: out_ready=0, samples 0..31.
  - Response: frame 0..15 is held unchanged; ovf pulses once, the cycle after sample 31. Raising out_ready drops out_valid next cycle.
- Simultaneous event:
  - Stimulus: out_ready=1 on the exact edge a new frame fires while one is held.
  - Response: new frame loaded; out_valid stays 1; ovf=0.
- Reset:
  - Stimulus: RST pulse after sample 7, then samples 0..15.
  - Response: all outputs 0 during reset; single correct frame afterwards.
